// File: rtl/rom_dl_pkg.sv
// Shared constants and state encoding for the ROM download path.
// Region bases describe the layout of the image on the download bus.
package rom_dl_pkg;

   localparam logic [19:0] SP        = 20'h00000;
   localparam logic [19:0] FG        = 20'h10000;
   localparam logic [19:0] BG        = 20'h20000;
   localparam logic [19:0] SND       = 20'h30000;
   localparam logic [19:0] MAIN0     = 20'h34000;
   localparam logic [19:0] MAIN1     = 20'h38000;
   localparam logic [19:0] MAIN2     = 20'h40000;
   localparam logic [19:0] LIMIT_DEF = 20'h41000;

   localparam int unsigned ENTRY_W = 28;

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} dl_state_t;

endpackage

// File: rtl/dl_fifo.sv
// Small synchronous FIFO buffering {address, data} download entries.
// Depth must be a power of two so the pointers wrap on their own.
module dl_fifo #(
   parameter int unsigned W = 28,
   parameter int unsigned D = 4
) (
   input  logic                 CL,
   input  logic                 RST_N,
   input  logic                 push,
   input  logic                 pop,
   input  logic [W-1:0]         din,
   output logic [W-1:0]         dout,
   output logic [$clog2(D):0]   count,
   output logic                 full,
   output logic                 empty
);

   localparam int unsigned AW = $clog2(D);

   logic [W-1:0]  mem [D];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(D));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge CL) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge CL or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/rom_dl_sender.sv
// Range-checks the HPS ioctl byte stream, queues it, and replays it as paced
// single-cycle DLEN writes while holding the core in reset until the image lands.
module rom_dl_sender #(
   parameter int unsigned FD      = 4,
   parameter logic [19:0] LIMIT   = rom_dl_pkg::LIMIT_DEF,
   parameter int unsigned GAP     = 1,
   parameter int unsigned POSTRST = 16
) (
   input  logic        CL,
   input  logic        RST_N,
   input  logic        IO_DL,
   input  logic        IO_WR,
   input  logic [24:0] IO_AD,
   input  logic [7:0]  IO_DT,
   output logic        IO_WAIT,
   output logic [19:0] DLAD,
   output logic [7:0]  DLDT,
   output logic        DLEN,
   output logic        BUSY,
   output logic        DONE,
   output logic        CPU_RST,
   output logic [15:0] CSUM,
   output logic        ERR
);

   import rom_dl_pkg::*;

   localparam int unsigned CW = $clog2(FD) + 1;
   localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int unsigned PW = (POSTRST > 0) ? $clog2(POSTRST + 1) : 1;

   dl_state_t            state, state_nx;
   logic                 dl_q, dl_rise, dl_fall;
   logic                 wr_ok, in_range, push, pop, reject;
   logic                 full, empty;
   logic [CW-1:0]        count, count_nx;
   logic [ENTRY_W-1:0]   din, dout;
   logic [GW-1:0]        gap_cnt;
   logic [PW-1:0]        post_cnt;
   logic [15:0]          csum_base;

   assign dl_rise  = IO_DL & ~dl_q;
   assign dl_fall  = ~IO_DL & dl_q;
   // A strobe in the rising-edge cycle already belongs to the new image.
   assign wr_ok    = IO_WR & IO_DL & (dl_rise | (state == LOAD));
   assign in_range = (IO_AD < {5'b0, LIMIT});
   assign push     = wr_ok & in_range & ~full;
   assign reject   = wr_ok & (~in_range | full);
   assign pop      = ~empty & (gap_cnt == '0);
   assign din      = {IO_AD[19:0], IO_DT};
   assign count_nx = count + CW'(push) - CW'(pop);
   assign csum_base = dl_rise ? 16'h0 : CSUM;

   assign BUSY    = (state == LOAD) || (state == DRAIN);
   assign DONE    = (state == rom_dl_pkg::DONE);
   assign CPU_RST = !((state == rom_dl_pkg::DONE) && (post_cnt == '0));

   dl_fifo #(.W(ENTRY_W), .D(FD)) u_fifo (
      .CL    (CL),
      .RST_N (RST_N),
      .push  (push),
      .pop   (pop),
      .din   (din),
      .dout  (dout),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  state_nx = IDLE;
         LOAD:  if (dl_fall) state_nx = DRAIN;
         DRAIN: if (empty && !DLEN) state_nx = rom_dl_pkg::DONE;
         rom_dl_pkg::DONE: state_nx = rom_dl_pkg::DONE;
         default: state_nx = IDLE;
      endcase
      if (dl_rise) state_nx = LOAD;
   end

   always_ff @(posedge CL or negedge RST_N) begin
      if (!RST_N) begin
         state    <= IDLE;
         dl_q     <= 1'b0;
         gap_cnt  <= '0;
         post_cnt <= '0;
         DLAD     <= '0;
         DLDT     <= '0;
         DLEN     <= 1'b0;
         IO_WAIT  <= 1'b0;
         CSUM     <= '0;
         ERR      <= 1'b0;
      end else begin
         state   <= state_nx;
         dl_q    <= IO_DL;
         DLEN    <= pop;
         IO_WAIT <= (count_nx >= CW'(FD - 1));
         if (pop) begin
            DLAD    <= dout[ENTRY_W-1:8];
            DLDT    <= dout[7:0];
            gap_cnt <= GW'(GAP - 1);
         end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GW'(1);
         end
         if (state != rom_dl_pkg::DONE && state_nx == rom_dl_pkg::DONE)
            post_cnt <= PW'(POSTRST);
         else if (state == rom_dl_pkg::DONE && post_cnt != '0)
            post_cnt <= post_cnt - PW'(1);
         if (dl_rise) begin
            CSUM <= '0;
            ERR  <= 1'b0;
         end
         if (push)   CSUM <= csum_base + {8'h0, IO_DT};
         if (reject) ERR  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rom_dl_sender.sv
// Directed bench for rom_dl_sender: default instance (a) and a GAP=3 instance (b)
// share one stimulus stream; writes seen on DLEN are logged for ordering checks.
module tb_rom_dl_sender;

   logic        CL = 1'b0;
   logic        RST_N;
   logic        IO_DL, IO_WR;
   logic [24:0] IO_AD;
   logic [7:0]  IO_DT;

   logic        a_IO_WAIT, a_DLEN, a_BUSY, a_DONE, a_CPU_RST, a_ERR;
   logic [19:0] a_DLAD;
   logic [7:0]  a_DLDT;
   logic [15:0] a_CSUM;
   logic        b_IO_WAIT, b_DLEN, b_BUSY, b_DONE, b_CPU_RST, b_ERR;
   logic [19:0] b_DLAD;
   logic [7:0]  b_DLDT;
   logic [15:0] b_CSUM;

   int ntests = 0;
   int nfail  = 0;
   int cyc    = 0;
   int na     = 0;
   int nb     = 0;
   logic [19:0] qa_ad[$];
   logic [7:0]  qa_dt[$];
   logic [19:0] qb_ad[$];
   logic [7:0]  qb_dt[$];
   int          qb_cyc[$];

   always #5 CL = ~CL;

   rom_dl_sender u_a (
      .CL(CL), .RST_N(RST_N), .IO_DL(IO_DL), .IO_WR(IO_WR), .IO_AD(IO_AD), .IO_DT(IO_DT),
      .IO_WAIT(a_IO_WAIT), .DLAD(a_DLAD), .DLDT(a_DLDT), .DLEN(a_DLEN), .BUSY(a_BUSY),
      .DONE(a_DONE), .CPU_RST(a_CPU_RST), .CSUM(a_CSUM), .ERR(a_ERR)
   );

   rom_dl_sender #(.FD(4), .GAP(3)) u_b (
      .CL(CL), .RST_N(RST_N), .IO_DL(IO_DL), .IO_WR(IO_WR), .IO_AD(IO_AD), .IO_DT(IO_DT),
      .IO_WAIT(b_IO_WAIT), .DLAD(b_DLAD), .DLDT(b_DLDT), .DLEN(b_DLEN), .BUSY(b_BUSY),
      .DONE(b_DONE), .CPU_RST(b_CPU_RST), .CSUM(b_CSUM), .ERR(b_ERR)
   );

   always @(negedge CL) begin
      cyc <= cyc + 1;
      if (a_DLEN === 1'b1) begin
         na <= na + 1;
         qa_ad.push_back(a_DLAD);
         qa_dt.push_back(a_DLDT);
      end
      if (b_DLEN === 1'b1) begin
         nb <= nb + 1;
         qb_ad.push_back(b_DLAD);
         qb_dt.push_back(b_DLDT);
         qb_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [24:0] ad, input logic [7:0] dt);
      IO_WR = 1'b1;
      IO_AD = ad;
      IO_DT = dt;
      @(negedge CL);
      IO_WR = 1'b0;
   endtask

   task automatic wait_done_and_release();
      int k = 0;
      while (a_DONE !== 1'b1 && k < 300) begin
         @(negedge CL);
         k++;
      end
      chk("done_reached", {31'b0, a_DONE}, 1);
      k = 0;
      while (a_CPU_RST !== 1'b0 && k < 100) begin
         @(negedge CL);
         k++;
      end
      chk("postrst_cycles", k, 16);
   endtask

   initial begin
      int na0, nb0;
      RST_N = 1'b0; IO_DL = 1'b0; IO_WR = 1'b0; IO_AD = '0; IO_DT = '0;
      repeat (3) @(negedge CL);
      chk("rst_cpu_rst", {31'b0, a_CPU_RST}, 1);
      chk("rst_done",    {31'b0, a_DONE}, 0);
      chk("rst_dlen",    {31'b0, a_DLEN}, 0);
      chk("rst_csum",    {16'b0, a_CSUM}, 0);
      chk("rst_err_wait_busy", {29'b0, a_ERR, a_IO_WAIT, a_BUSY}, 0);
      chk("rst_dlad_dldt", {4'b0, a_DLAD, a_DLDT}, 0);
      RST_N = 1'b1;

      // Idle: nothing is written, core stays in reset.
      repeat (100) @(negedge CL);
      chk("idle_no_dlen", na + nb, 0);
      chk("idle_cpu_rst", {31'b0, a_CPU_RST}, 1);

      // Single byte: latency, data, checksum, post-reset hold.
      IO_DL = 1'b1;
      repeat (3) @(negedge CL);
      chk("load_busy", {31'b0, a_BUSY}, 1);
      send(25'h34000, 8'hA5);
      chk("lat_n1_dlen", {31'b0, a_DLEN}, 0);
      @(negedge CL);
      chk("lat_n2_dlen", {31'b0, a_DLEN}, 1);
      chk("lat_n2_dlad", {12'b0, a_DLAD}, 32'h34000);
      chk("lat_n2_dldt", {24'b0, a_DLDT}, 32'hA5);
      chk("single_csum", {16'b0, a_CSUM}, 32'h00A5);
      @(negedge CL);
      chk("dlen_one_cycle", {31'b0, a_DLEN}, 0);
      chk("dlad_hold", {12'b0, a_DLAD}, 32'h34000);
      IO_DL = 1'b0;
      wait_done_and_release();
      chk("done_not_busy", {31'b0, a_BUSY}, 0);

      // Range limit: both rejected bytes leave no trace but ERR.
      IO_DL = 1'b1;
      @(negedge CL);
      chk("rise_done_clr", {31'b0, a_DONE}, 0);
      chk("rise_cpu_rst", {31'b0, a_CPU_RST}, 1);
      chk("rise_csum_clr", {16'b0, a_CSUM}, 0);
      na0 = na;
      send(25'h41000, 8'h11);
      send(25'h100000, 8'h22);
      repeat (4) @(negedge CL);
      chk("range_err", {31'b0, a_ERR}, 1);
      chk("range_csum", {16'b0, a_CSUM}, 0);
      chk("range_no_dlen", na - na0, 0);
      send(25'h40FFF, 8'h33);
      repeat (3) @(negedge CL);
      chk("range_next_cnt", na - na0, 1);
      chk("range_next_ad", {12'b0, qa_ad[qa_ad.size()-1]}, 32'h40FFF);
      chk("range_next_dt", {24'b0, qa_dt[qa_dt.size()-1]}, 32'h33);
      chk("range_next_csum", {16'b0, a_CSUM}, 32'h33);
      chk("range_err_sticky", {31'b0, a_ERR}, 1);
      IO_DL = 1'b0;
      wait_done_and_release();

      // Pacing with GAP=3: overflow drops, order, back-pressure timing.
      IO_DL = 1'b1;
      @(negedge CL);
      chk("rise_err_clr", {30'b0, a_ERR, b_ERR}, 0);
      @(negedge CL);
      nb0 = nb;
      qb_ad.delete(); qb_dt.delete(); qb_cyc.delete();
      for (int i = 0; i < 8; i++) begin
         if (i == 3) chk("wait_before", {31'b0, b_IO_WAIT}, 0);
         if (i == 4) chk("wait_at3", {31'b0, b_IO_WAIT}, 1);
         send(25'(i), 8'(8'h10 + i));
      end
      repeat (20) @(negedge CL);
      chk("gap_count", nb - nb0, 6);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("gap_ad%0d", i), {12'b0, qb_ad[i]}, 32'(i));
         chk($sformatf("gap_dt%0d", i), {24'b0, qb_dt[i]}, 32'(8'h10 + i));
      end
      for (int i = 1; i < 6; i++)
         chk($sformatf("gap_space%0d", i), qb_cyc[i] - qb_cyc[i-1], 3);
      chk("gap_err", {31'b0, b_ERR}, 1);
      chk("gap_csum", {16'b0, b_CSUM}, 32'h006F);
      chk("nogap_csum", {16'b0, a_CSUM}, 32'h009C);
      chk("nogap_err", {31'b0, a_ERR}, 0);

      // Reset with three entries queued in b.
      for (int i = 0; i < 4; i++) send(25'h100 + 25'(i), 8'h40);
      chk("b_three_queued", {31'b0, b_IO_WAIT}, 1);
      nb0 = nb;
      RST_N = 1'b0;
      IO_DL = 1'b0;
      #1;
      chk("async_rst_dlen", {31'b0, b_DLEN}, 0);
      @(negedge CL);
      RST_N = 1'b1;
      repeat (20) @(negedge CL);
      chk("rst_no_more_dlen", nb - nb0, 0);
      chk("rst_b_csum", {16'b0, b_CSUM}, 0);
      chk("rst_b_cpu_rst", {31'b0, b_CPU_RST}, 1);
      chk("rst_b_empty_wait", {30'b0, b_IO_WAIT, b_BUSY}, 0);

      // Image of 0x1000 bytes of 0x01, first strobe in the rising-edge cycle.
      na0 = na;
      IO_DL = 1'b1;
      for (int i = 0; i < 32'h1000; i++) send(25'h40000 + 25'(i), 8'h01);
      repeat (4) @(negedge CL);
      chk("img_csum", {16'b0, a_CSUM}, 32'h1000);
      chk("img_err", {31'b0, a_ERR}, 0);
      chk("img_writes", na - na0, 32'h1000);
      chk("img_last_ad", {12'b0, qa_ad[qa_ad.size()-1]}, 32'h40FFF);
      IO_DL = 1'b0;
      wait_done_and_release();

      // Checksum wrap at 16 bits.
      IO_DL = 1'b1;
      @(negedge CL);
      chk("wrap_clr", {16'b0, a_CSUM}, 0);
      for (int i = 0; i < 257; i++) send(25'h30000 + 25'(i), 8'hFF);
      repeat (3) @(negedge CL);
      chk("wrap_ffff", {16'b0, a_CSUM}, 32'hFFFF);
      send(25'h30200, 8'h02);
      repeat (3) @(negedge CL);
      chk("wrap_0001", {16'b0, a_CSUM}, 32'h0001);
      IO_DL = 1'b0;
      repeat (5) @(negedge CL);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
